// File: rtl/reg_file_if.sv
// Register file access bus between decode/writeback (master) and the
// register file (slave).
//   r     : mode select, 1 = read cycle, 0 = write cycle
//   rs1   : read port A register index
//   rs2   : read port B register index
//   rd    : write register index
//   din   : write data
//   rs1v  : registered read data, port A
//   rs2v  : registered read data, port B
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  r;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] rs1v;
  logic [DATA_WIDTH-1:0] rs2v;

  modport master (
    output r, rs1, rs2, rd, din,
    input  rs1v, rs2v
  );

  modport slave (
    input  r, rs1, rs2, rd, din,
    output rs1v, rs2v
  );
endinterface

// File: rtl/reg_file.sv
// 32-entry general-purpose register file: one write port, two registered
// read ports, with a single read/write mode select. Register 0 reads as zero.
//   clk : system clock, all updates on the rising edge
//   rst : asynchronous reset, active-low; clears all registers and outputs
//   bus : reg_file_if slave (r, rs1, rs2, rd, din in; rs1v, rs2v out)
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] rs1v_q;
  logic [DATA_WIDTH-1:0] rs2v_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      rs1v_q <= '0;
      rs2v_q <= '0;
    end else if (bus.r) begin
      // Read cycle: contents untouched; index 0 forced to zero explicitly.
      rs1v_q <= (bus.rs1 == '0) ? '0 : regs[bus.rs1];
      rs2v_q <= (bus.rs2 == '0) ? '0 : regs[bus.rs2];
    end else if (bus.rd != '0) begin
      // Write cycle: outputs hold; writes to register 0 are dropped.
      regs[bus.rd] <= bus.din;
    end
  end

  assign bus.rs1v = rs1v_q;
  assign bus.rs2v = rs2v_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  logic clk;
  logic rst;

  int compared;
  int mismatched;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write cycle; outputs must keep their previous values across the edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [31:0] hold1, input logic [31:0] hold2,
                    input string tag);
    @(negedge clk);
    bus.r   = 1'b0;
    bus.rd  = a;
    bus.din = d;
    @(posedge clk);
    #1;
    check({tag, "_hold1"}, bus.rs1v, hold1);
    check({tag, "_hold2"}, bus.rs2v, hold2);
  endtask

  // Read cycle; data must be visible just after the sampling edge.
  task automatic rdp(input logic [4:0] a, input logic [4:0] b,
                     input logic [31:0] e1, input logic [31:0] e2,
                     input string tag);
    @(negedge clk);
    bus.r   = 1'b1;
    bus.rs1 = a;
    bus.rs2 = b;
    @(posedge clk);
    #1;
    check({tag, "_rs1v"}, bus.rs1v, e1);
    check({tag, "_rs2v"}, bus.rs2v, e2);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst     = 1'b0;
    bus.r   = 1'b1;
    bus.rs1 = '0;
    bus.rs2 = '0;
    bus.rd  = '0;
    bus.din = '0;

    // Reset held with clock running.
    repeat (2) @(posedge clk);
    #1;
    check("rst_rs1v", bus.rs1v, 32'd0);
    check("rst_rs2v", bus.rs2v, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    rdp(5'd7, 5'd31, 32'd0, 32'd0, "rst_read");

    // Basic write then read.
    wr(5'd5,  32'd150, 32'd0, 32'd0, "wr5");
    wr(5'd10, 32'd300, 32'd0, 32'd0, "wr10");
    rdp(5'd5, 5'd10, 32'd150, 32'd300, "rd5_10");

    // Interleaved.
    wr(5'd25, 32'd53, 32'd150, 32'd300, "wr25");
    rdp(5'd10, 5'd25, 32'd300, 32'd53, "rd10_25");
    rdp(5'd25, 5'd5,  32'd53,  32'd150, "rd25_5");

    // Register 0 is hardwired to zero.
    wr(5'd0, 32'hDEADBEEF, 32'd53, 32'd150, "wr0");
    rdp(5'd0, 5'd0, 32'd0, 32'd0, "rd0_0");

    // Same index on both ports, full data width.
    wr(5'd31, 32'hFFFFFFFF, 32'd0, 32'd0, "wr31");
    rdp(5'd31, 5'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, "rd31_31");

    // Populated registers survive until reset.
    rdp(5'd5, 5'd10, 32'd150, 32'd300, "pre_rst");

    // Asynchronous reset pulse between clock edges.
    @(negedge clk);
    bus.r   = 1'b1;
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd5;
    #1 rst = 1'b0;
    #1;
    check("async_rs1v", bus.rs1v, 32'd0);
    check("async_rs2v", bus.rs2v, 32'd0);
    #1 rst = 1'b1;
    rdp(5'd5, 5'd31, 32'd0, 32'd0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
